// File: rtl/mfb_meta_extractor_pkg.sv
// Shared constants and width helpers for the MFB metadata extractor and its MVB FIFO.
package mfb_meta_extractor_pkg;

  localparam int MODE_SOF = 0;
  localparam int MODE_EOF = 1;

  // Position fields collapse to one bit when a region/block has a single slot.
  function automatic int pos_w(input int slots);
    return (slots <= 1) ? 1 : $clog2(slots);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_REGIONS     = 4;
  localparam int DEF_REGION_SIZE = 8;
  localparam int DEF_BLOCK_SIZE  = 8;
  localparam int DEF_ITEM_WIDTH  = 8;
  localparam int DEF_META_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH  = 16;

  localparam int MFB_DATA_W = DEF_REGIONS*DEF_REGION_SIZE*DEF_BLOCK_SIZE*DEF_ITEM_WIDTH;
  localparam int SOF_POS_W  = DEF_REGIONS*pos_w(DEF_REGION_SIZE);
  localparam int EOF_POS_W  = DEF_REGIONS*pos_w(DEF_REGION_SIZE*DEF_BLOCK_SIZE);
  localparam int MVB_DATA_W = DEF_REGIONS*DEF_META_WIDTH;
  localparam int CNT_W      = cnt_w(DEF_FIFO_DEPTH);

endpackage

// File: rtl/mfb_meta_extractor_fifo_mvb_fwft_fifo.sv
// First-word-fall-through FIFO with an explicit occupancy counter; head word is
// presented on rd_data_o whenever empty_o is low.
module mvb_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/mfb_meta_extractor_fifo.sv
// Registers an MFB stream once and peels off per-region metadata of boundary
// regions (SOF or EOF) into a buffered MVB stream.
module mfb_meta_extractor_fifo
  import mfb_meta_extractor_pkg::*;
#(
  parameter int MFB_REGIONS     = 4,
  parameter int MFB_REGION_SIZE = 8,
  parameter int MFB_BLOCK_SIZE  = 8,
  parameter int MFB_ITEM_WIDTH  = 8,
  parameter int MFB_META_WIDTH  = 32,
  parameter int EXTRACT_MODE    = MODE_SOF,
  parameter int FIFO_DEPTH      = 16,
  localparam int DATA_W = MFB_REGIONS*MFB_REGION_SIZE*MFB_BLOCK_SIZE*MFB_ITEM_WIDTH,
  localparam int SOFP_W = MFB_REGIONS*pos_w(MFB_REGION_SIZE),
  localparam int EOFP_W = MFB_REGIONS*pos_w(MFB_REGION_SIZE*MFB_BLOCK_SIZE),
  localparam int MVB_W  = MFB_REGIONS*MFB_META_WIDTH,
  localparam int CW     = cnt_w(FIFO_DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [DATA_W-1:0]      RX_DATA,
  input  logic [MVB_W-1:0]       RX_META,
  input  logic [MFB_REGIONS-1:0] RX_SOF,
  input  logic [MFB_REGIONS-1:0] RX_EOF,
  input  logic [SOFP_W-1:0]      RX_SOF_POS,
  input  logic [EOFP_W-1:0]      RX_EOF_POS,
  input  logic                   RX_SRC_RDY,
  output logic                   RX_DST_RDY,
  output logic [DATA_W-1:0]      TX_MFB_DATA,
  output logic [MVB_W-1:0]       TX_MFB_META,
  output logic [MFB_REGIONS-1:0] TX_MFB_SOF,
  output logic [MFB_REGIONS-1:0] TX_MFB_EOF,
  output logic [SOFP_W-1:0]      TX_MFB_SOF_POS,
  output logic [EOFP_W-1:0]      TX_MFB_EOF_POS,
  output logic                   TX_MFB_SRC_RDY,
  input  logic                   TX_MFB_DST_RDY,
  output logic [MVB_W-1:0]       TX_MVB_DATA,
  output logic [MFB_REGIONS-1:0] TX_MVB_VLD,
  output logic                   TX_MVB_SRC_RDY,
  input  logic                   TX_MVB_DST_RDY,
  output logic [CW-1:0]          FIFO_STATUS
);

  localparam int FIFO_W = MVB_W + MFB_REGIONS;

  logic                   mfb_vld_q, mfb_vld_d;
  logic [DATA_W-1:0]      data_q;
  logic [MVB_W-1:0]       meta_q;
  logic [MFB_REGIONS-1:0] sof_q, eof_q;
  logic [SOFP_W-1:0]      sof_pos_q;
  logic [EOFP_W-1:0]      eof_pos_q;

  logic                   rx_xfer, fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [MFB_REGIONS-1:0] sel, head_vld;
  logic [MVB_W-1:0]       head_meta;

  assign sel = (EXTRACT_MODE == MODE_EOF) ? RX_EOF : RX_SOF;

  // Full FIFO blocks every word, boundary or not, so MVB order can never slip.
  assign RX_DST_RDY = !fifo_full && (!mfb_vld_q || TX_MFB_DST_RDY);
  assign rx_xfer    = RX_SRC_RDY && RX_DST_RDY;
  assign fifo_wr    = rx_xfer && (|sel);
  assign fifo_rd    = !fifo_empty && TX_MVB_DST_RDY;

  always_comb begin
    mfb_vld_d = mfb_vld_q;
    if (rx_xfer)             mfb_vld_d = 1'b1;
    else if (TX_MFB_DST_RDY) mfb_vld_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mfb_vld_q <= 1'b0;
      sof_q     <= '0;
      eof_q     <= '0;
    end else begin
      mfb_vld_q <= mfb_vld_d;
      if (rx_xfer) begin
        sof_q <= RX_SOF;
        eof_q <= RX_EOF;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_xfer) begin
      data_q    <= RX_DATA;
      meta_q    <= RX_META;
      sof_pos_q <= RX_SOF_POS;
      eof_pos_q <= RX_EOF_POS;
    end
  end

  mvb_fwft_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_n_i   (RESET_N),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({RX_META, sel}),
    .rd_en_i   (fifo_rd),
    .rd_data_o ({head_meta, head_vld}),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (FIFO_STATUS)
  );

  assign TX_MFB_DATA    = data_q;
  assign TX_MFB_META    = meta_q;
  assign TX_MFB_SOF     = sof_q;
  assign TX_MFB_EOF     = eof_q;
  assign TX_MFB_SOF_POS = sof_pos_q;
  assign TX_MFB_EOF_POS = eof_pos_q;
  assign TX_MFB_SRC_RDY = mfb_vld_q;

  assign TX_MVB_DATA    = head_meta;
  assign TX_MVB_VLD     = fifo_empty ? '0 : head_vld;
  assign TX_MVB_SRC_RDY = !fifo_empty;

endmodule

// File: tb/tb_mfb_meta_extractor_fifo.sv
// Scoreboard bench: an SOF-mode extractor (depth 4) carries most scenarios, an
// EOF-mode instance covers boundary selection.
module tb_mfb_meta_extractor_fifo;

  localparam int R = 4, RS = 2, BS = 2, IW = 8, MW = 8, DEPTH = 4;
  localparam int DW = R*RS*BS*IW, SPW = R*1, EPW = R*2, MVW = R*MW, CW = 3;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [MVW-1:0] meta;
    logic [R-1:0]   sof;
    logic [R-1:0]   eof;
    logic [SPW-1:0] sofp;
    logic [EPW-1:0] eofp;
  } mfb_t;

  typedef struct packed {
    logic [MVW-1:0] meta;
    logic [R-1:0]   vld;
  } mvb_t;

  logic CLK = 0, RESET_N = 1;
  logic [DW-1:0] rx_data = '0;
  logic [MVW-1:0] rx_meta = '0;
  logic [R-1:0] rx_sof = '0, rx_eof = '0;
  logic [SPW-1:0] rx_sofp = '0;
  logic [EPW-1:0] rx_eofp = '0;
  logic src0 = 0, src1 = 0, mfb_dst = 1, mvb_dst = 1, e_mfb_dst = 1, e_mvb_dst = 1;
  logic dst0, dst1;

  logic [DW-1:0] t_data, e_data;
  logic [MVW-1:0] t_meta, e_meta, t_mvb_data, e_mvb_data;
  logic [R-1:0] t_sof, t_eof, e_sof, e_eof, t_mvb_vld, e_mvb_vld;
  logic [SPW-1:0] t_sofp, e_sofp;
  logic [EPW-1:0] t_eofp, e_eofp;
  logic t_src, e_src, t_mvb_src, e_mvb_src;
  logic [CW-1:0] status, e_status;

  int checks = 0, errors = 0, cyc = 0, e_mvb_seen = 0;
  mfb_t mfb_q[$];
  mvb_t mvb_q[$];
  mvb_t e_mvb_q[$];

  always #5 CLK = ~CLK;

  mfb_meta_extractor_fifo #(
    .MFB_REGIONS(R), .MFB_REGION_SIZE(RS), .MFB_BLOCK_SIZE(BS), .MFB_ITEM_WIDTH(IW),
    .MFB_META_WIDTH(MW), .EXTRACT_MODE(0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(rx_data), .RX_META(rx_meta), .RX_SOF(rx_sof),
    .RX_EOF(rx_eof), .RX_SOF_POS(rx_sofp), .RX_EOF_POS(rx_eofp), .RX_SRC_RDY(src0),
    .RX_DST_RDY(dst0), .TX_MFB_DATA(t_data), .TX_MFB_META(t_meta), .TX_MFB_SOF(t_sof),
    .TX_MFB_EOF(t_eof), .TX_MFB_SOF_POS(t_sofp), .TX_MFB_EOF_POS(t_eofp),
    .TX_MFB_SRC_RDY(t_src), .TX_MFB_DST_RDY(mfb_dst), .TX_MVB_DATA(t_mvb_data),
    .TX_MVB_VLD(t_mvb_vld), .TX_MVB_SRC_RDY(t_mvb_src), .TX_MVB_DST_RDY(mvb_dst),
    .FIFO_STATUS(status)
  );

  mfb_meta_extractor_fifo #(
    .MFB_REGIONS(R), .MFB_REGION_SIZE(RS), .MFB_BLOCK_SIZE(BS), .MFB_ITEM_WIDTH(IW),
    .MFB_META_WIDTH(MW), .EXTRACT_MODE(1), .FIFO_DEPTH(DEPTH)
  ) dut_eof (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(rx_data), .RX_META(rx_meta), .RX_SOF(rx_sof),
    .RX_EOF(rx_eof), .RX_SOF_POS(rx_sofp), .RX_EOF_POS(rx_eofp), .RX_SRC_RDY(src1),
    .RX_DST_RDY(dst1), .TX_MFB_DATA(e_data), .TX_MFB_META(e_meta), .TX_MFB_SOF(e_sof),
    .TX_MFB_EOF(e_eof), .TX_MFB_SOF_POS(e_sofp), .TX_MFB_EOF_POS(e_eofp),
    .TX_MFB_SRC_RDY(e_src), .TX_MFB_DST_RDY(e_mfb_dst), .TX_MVB_DATA(e_mvb_data),
    .TX_MVB_VLD(e_mvb_vld), .TX_MVB_SRC_RDY(e_mvb_src), .TX_MVB_DST_RDY(e_mvb_dst),
    .FIFO_STATUS(e_status)
  );

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  function automatic mfb_t rand_word(input logic [R-1:0] sof, input logic [R-1:0] eof);
    mfb_t w;
    w.data = {$urandom, $urandom};
    w.meta = $urandom;
    w.sof  = sof;
    w.eof  = eof;
    w.sofp = SPW'($urandom);
    w.eofp = EPW'($urandom);
    return w;
  endfunction

  // Only regions flagged valid carry defined metadata.
  function automatic bit mvb_match(input logic [MVW-1:0] d, input logic [R-1:0] v, input mvb_t e);
    if (v !== e.vld) return 0;
    for (int r = 0; r < R; r++)
      if (e.vld[r] && d[r*MW +: MW] !== e.meta[r*MW +: MW]) return 0;
    return 1;
  endfunction

  // Monitor: compare outputs before recording this edge's RX transfer.
  initial begin
    mfb_t em, got;
    mvb_t ev;
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        if (t_src && mfb_dst) begin
          checks++;
          got = {t_data, t_meta, t_sof, t_eof, t_sofp, t_eofp};
          if (mfb_q.size() == 0) begin
            errors++; $display("FAIL mfb_unexpected got=%h", got);
          end else begin
            em = mfb_q.pop_front();
            if (got !== em) begin errors++; $display("FAIL mfb_word got=%h exp=%h", got, em); end
          end
        end
        checks++;
        if (!t_mvb_src && t_mvb_vld !== '0) begin
          errors++; $display("FAIL mvb_vld_mask got=%b exp=0000", t_mvb_vld);
        end
        if (t_mvb_src && mvb_dst) begin
          checks++;
          if (mvb_q.size() == 0) begin
            errors++; $display("FAIL mvb_unexpected got vld=%b", t_mvb_vld);
          end else begin
            ev = mvb_q.pop_front();
            if (!mvb_match(t_mvb_data, t_mvb_vld, ev)) begin
              errors++;
              $display("FAIL mvb_word got meta=%h vld=%b exp meta=%h vld=%b", t_mvb_data, t_mvb_vld, ev.meta, ev.vld);
            end
          end
        end
        if (e_mvb_src) begin
          checks++; e_mvb_seen++;
          if (e_mvb_q.size() == 0) begin
            errors++; $display("FAIL eof_mvb_unexpected got vld=%b", e_mvb_vld);
          end else begin
            ev = e_mvb_q.pop_front();
            if (!mvb_match(e_mvb_data, e_mvb_vld, ev)) begin
              errors++;
              $display("FAIL eof_mvb_word got meta=%h vld=%b exp meta=%h vld=%b", e_mvb_data, e_mvb_vld, ev.meta, ev.vld);
            end
          end
        end
        if (src0 && dst0) begin
          mfb_q.push_back({rx_data, rx_meta, rx_sof, rx_eof, rx_sofp, rx_eofp});
          if (|rx_sof) mvb_q.push_back({rx_meta, rx_sof});
        end
        if (src1 && dst1 && |rx_eof) e_mvb_q.push_back({rx_meta, rx_eof});
      end
    end
  end

  task automatic drive(input mfb_t w, input bit which);
    rx_data = w.data; rx_meta = w.meta; rx_sof = w.sof; rx_eof = w.eof;
    rx_sofp = w.sofp; rx_eofp = w.eofp;
    if (which) src1 = 1; else src0 = 1;
  endtask

  task automatic send(input mfb_t w, input bit which);
    bit ok;
    ok = 0;
    drive(w, which);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if ((which ? dst1 : dst0) === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL send_timeout got=no_accept exp=accept"); end
    @(posedge CLK); #1;
    src0 = 0; src1 = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (mfb_q.size() == 0 && mvb_q.size() == 0 && e_mvb_q.size() == 0) begin ok = 1; break; end
    end
    checks += 2;
    if (!ok) begin
      errors++; $display("FAIL drain got mfb=%0d mvb=%0d eof=%0d pending exp=0", mfb_q.size(), mvb_q.size(), e_mvb_q.size());
    end
    if (status !== '0) begin errors++; $display("FAIL drain_status got=%0d exp=0", status); end
  endtask

  task automatic test_reset();
    #1 RESET_N = 0;
    #1;
    checks += 5;
    if (t_src !== 0)     begin errors++; $display("FAIL rst_mfb_src got=%b exp=0", t_src); end
    if (t_mvb_src !== 0) begin errors++; $display("FAIL rst_mvb_src got=%b exp=0", t_mvb_src); end
    if (t_mvb_vld !== 0) begin errors++; $display("FAIL rst_mvb_vld got=%b exp=0", t_mvb_vld); end
    if (status !== 0)    begin errors++; $display("FAIL rst_status got=%0d exp=0", status); end
    if (t_sof !== 0 || t_eof !== 0) begin errors++; $display("FAIL rst_flags got=%b/%b exp=0", t_sof, t_eof); end
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1;
    checks++;
    if (dst0 !== 1) begin errors++; $display("FAIL rst_dst_rdy got=%b exp=1", dst0); end
  endtask

  task automatic test_basic();
    mfb_t w;
    mfb_dst = 1; mvb_dst = 1;
    w = rand_word(4'b0101, 4'b0000);
    w.meta = 32'hDDCCBBAA;
    send(w, 0);
    checks += 3;
    if (t_src !== 1)          begin errors++; $display("FAIL basic_latency got=%b exp=1", t_src); end
    if (status !== 1)         begin errors++; $display("FAIL basic_status got=%0d exp=1", status); end
    if (t_mvb_vld !== 4'b0101) begin errors++; $display("FAIL basic_vld got=%b exp=0101", t_mvb_vld); end
    @(posedge CLK); #1;
    checks += 2;
    if (status !== 0) begin errors++; $display("FAIL basic_status_ret got=%0d exp=0", status); end
    if (t_src !== 0)  begin errors++; $display("FAIL basic_src_drop got=%b exp=0", t_src); end
    send(rand_word(4'b0000, 4'b0011), 0);
    checks++;
    if (status !== 0) begin errors++; $display("FAIL no_boundary_status got=%0d exp=0", status); end
    drain();
  endtask

  task automatic test_eof_mode();
    int seen0;
    seen0 = e_mvb_seen;
    send(rand_word(4'b0001, 4'b0000), 1);
    send(rand_word(4'b0000, 4'b0000), 1);
    send(rand_word(4'b0000, 4'b0100), 1);
    send(rand_word(4'b0010, 4'b0010), 1);
    drain();
    checks++;
    if (e_mvb_seen - seen0 !== 2) begin
      errors++; $display("FAIL eof_count got=%0d exp=2", e_mvb_seen - seen0);
    end
  endtask

  task automatic test_fifo_full();
    mfb_dst = 1; mvb_dst = 0;
    for (int i = 0; i < 4; i++) send(rand_word(4'b0001 << (i % 4), 4'b0000), 0);
    drive(rand_word(4'b1000, 4'b0000), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks += 3;
      if (dst0 !== 0)      begin errors++; $display("FAIL full_dst_rdy got=%b exp=0", dst0); end
      if (status !== 4)    begin errors++; $display("FAIL full_status got=%0d exp=4", status); end
      if (t_mvb_src !== 1) begin errors++; $display("FAIL full_mvb_src got=%b exp=1", t_mvb_src); end
    end
    @(posedge CLK); #1 mvb_dst = 1;
    @(negedge CLK);
    checks++;
    if (dst0 !== 0) begin errors++; $display("FAIL full_pop_cycle_dst got=%b exp=0", dst0); end
    @(posedge CLK); #1 mvb_dst = 0;
    @(negedge CLK);
    checks++;
    if (dst0 !== 1) begin errors++; $display("FAIL reopen_dst got=%b exp=1", dst0); end
    @(posedge CLK); #1;
    src0 = 0;
    checks++;
    if (status !== 4) begin errors++; $display("FAIL refill_status got=%0d exp=4", status); end
    mvb_dst = 1;
    send(rand_word(4'b0110, 4'b0000), 0);
    drain();
  endtask

  task automatic test_mfb_backpressure();
    int t0;
    mfb_dst = 0; mvb_dst = 1;
    send(rand_word(4'b0001, 4'b0001), 0);
    drive(rand_word(4'b0000, 4'b0100), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks += 3;
      if (dst0 !== 0)  begin errors++; $display("FAIL bp_dst_rdy got=%b exp=0", dst0); end
      if (t_src !== 1) begin errors++; $display("FAIL bp_src got=%b exp=1", t_src); end
      if (t_data !== mfb_q[0].data || t_meta !== mfb_q[0].meta) begin
        errors++; $display("FAIL bp_hold got=%h exp=%h", t_data, mfb_q[0].data);
      end
    end
    @(posedge CLK); #1 mfb_dst = 1;
    t0 = cyc;
    send({rx_data, rx_meta, rx_sof, rx_eof, rx_sofp, rx_eofp}, 0);
    for (int i = 0; i < 7; i++) send(rand_word(R'($urandom), R'($urandom)), 0);
    checks++;
    if (cyc - t0 !== 8) begin errors++; $display("FAIL stream_rate got=%0d cycles exp=8", cyc - t0); end
    drain();
  endtask

  task automatic test_push_pop();
    mfb_dst = 1; mvb_dst = 0;
    send(rand_word(4'b0011, 4'b0000), 0);
    send(rand_word(4'b1100, 4'b0000), 0);
    checks++;
    if (status !== 2) begin errors++; $display("FAIL pp_fill got=%0d exp=2", status); end
    mvb_dst = 1;
    for (int i = 0; i < 10; i++) begin
      send(rand_word(R'($urandom) | 4'b0001, 4'b0000), 0);
      checks++;
      if (status !== 2) begin errors++; $display("FAIL pp_status got=%0d exp=2", status); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    mfb_dst = 1; mvb_dst = 0;
    for (int i = 0; i < 3; i++) send(rand_word(4'b0101, 4'b0000), 0);
    checks++;
    if (status !== 3) begin errors++; $display("FAIL mid_fill got=%0d exp=3", status); end
    drive(rand_word(4'b1111, 4'b0000), 0);
    #2;
    RESET_N = 0; src0 = 0;
    mfb_q.delete(); mvb_q.delete(); e_mvb_q.delete();
    #1;
    checks += 4;
    if (t_src !== 0)     begin errors++; $display("FAIL mid_rst_mfb_src got=%b exp=0", t_src); end
    if (t_mvb_src !== 0) begin errors++; $display("FAIL mid_rst_mvb_src got=%b exp=0", t_mvb_src); end
    if (status !== 0)    begin errors++; $display("FAIL mid_rst_status got=%0d exp=0", status); end
    if (t_mvb_vld !== 0) begin errors++; $display("FAIL mid_rst_vld got=%b exp=0", t_mvb_vld); end
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1;
    mvb_dst = 1;
    for (int i = 0; i < 3; i++) send(rand_word(R'($urandom), 4'b0000), 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_eof_mode();
    test_fifo_full();
    test_mfb_backpressure();
    test_push_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mfb_meta_extractor_fifo.md
Name: mfb_meta_extractor_fifo

Overview:
Parametrised successor of the MFB metadata extractor. It passes an MFB stream through a single register stage. For every region carrying a packet boundary, it extracts that region's metadata onto a separate MVB stream. The boundary is SOF or EOF, selectable by parameter. MVB words are buffered in an internal FWFT FIFO, so a slow MVB consumer does not stall the MFB path until the FIFO fills. The block sits between MFB producers (e.g. RX MAC/DMA) and units that need per-packet metadata out of band.

Parameters:
MFB_REGIONS, 4, number of MFB regions; also the number of MVB items
MFB_REGION_SIZE, 8, blocks per region
MFB_BLOCK_SIZE, 8, items per block
MFB_ITEM_WIDTH, 8, bits per item
MFB_META_WIDTH, 32, metadata bits per region and per MVB item
EXTRACT_MODE, 0, 0 = take metadata of regions with SOF; 1 = take metadata of regions with EOF
FIFO_DEPTH, 16, MVB FIFO depth in MVB words; power of two, at least 2

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
RX_DATA  in  REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH  MFB data
RX_META  in  REGIONS*META_WIDTH  per-region metadata
RX_SOF  in  REGIONS  start-of-frame flags
RX_EOF  in  REGIONS  end-of-frame flags
RX_SOF_POS  in  REGIONS*log2(REGION_SIZE)  SOF block position
RX_EOF_POS  in  REGIONS*log2(REGION_SIZE*BLOCK_SIZE)  EOF item position
RX_SRC_RDY  in  1  RX word valid
RX_DST_RDY  out  1  RX word accepted
TX_MFB_DATA, TX_MFB_META, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS, TX_MFB_EOF_POS  out  same as RX  registered MFB copy
TX_MFB_SRC_RDY  out  1  TX MFB word valid
TX_MFB_DST_RDY  in  1  TX MFB word accepted
TX_MVB_DATA  out  REGIONS*META_WIDTH  extracted metadata
TX_MVB_VLD  out  REGIONS  per-item valid
TX_MVB_SRC_RDY  out  1  MVB word valid
TX_MVB_DST_RDY  in  1  MVB word accepted
FIFO_STATUS  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (RESET_N low, asynchronous): FIFO pointers and occupancy cleared. TX_MFB_SRC_RDY=0, TX_MVB_SRC_RDY=0, TX_MVB_VLD=0, FIFO_STATUS=0, all TX_MFB flags 0. Data registers need no reset. Any in-flight words are discarded.
- The RX transfer condition is RX_SRC_RDY and RX_DST_RDY.
- RX_DST_RDY = (FIFO occupancy < FIFO_DEPTH) and (TX_MFB_SRC_RDY=0 or TX_MFB_DST_RDY=1). This is combinational from TX_MFB_DST_RDY and registered state only. RX_DST_RDY is deasserted whenever the FIFO is full, even for words with no boundary.
- MFB path on an RX transfer: all RX fields are registered into the TX_MFB outputs; TX_MFB_SRC_RDY=1 on the next cycle, so latency is 1 cycle. The word is held while TX_MFB_DST_RDY=0. TX_MFB_SRC_RDY drops on acceptance unless a new word is loaded in the same cycle.
- Extraction: sel = RX_SOF when EXTRACT_MODE=0, RX_EOF when EXTRACT_MODE=1.
  - If the transfer occurs and sel is not all-zero, one FIFO word {RX_META, sel} is written, with VLD = sel.
  - If sel is all-zero, nothing is written.
  - A region carrying both SOF and EOF yields at most one item.
- MVB output: FWFT. TX_MVB_SRC_RDY = FIFO not empty. TX_MVB_DATA and TX_MVB_VLD show the head word. TX_MVB_VLD is masked to 0 when the FIFO is empty. A word becomes visible 1 cycle after its write. The head is popped when TX_MVB_SRC_RDY and TX_MVB_DST_RDY.
- Simultaneous pop and write:
  - Occupancy is unchanged.
  - When the FIFO is full, the write is impossible because RX_DST_RDY=0; a pop in that cycle reopens RX_DST_RDY on the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is an explicit counter, range 0..FIFO_DEPTH. FIFO_STATUS equals this counter, registered.
- MVB word order equals RX word order. The MFB and MVB streams are otherwise independent; the MFB output may run ahead of the MVB output by up to FIFO_DEPTH words.

Decomposition:
- Shared package mfb_meta_extractor_pkg holds:
  - the derived widths (MFB_DATA_W, SOF_POS_W, EOF_POS_W, MVB_DATA_W, CNT_W);
  - the extract-mode constants MODE_SOF=0 and MODE_EOF=1.
- One natural sub-module: mvb_fwft_fifo. Parametric width and depth, register array, explicit occupancy counter, async active-low reset. It is reusable elsewhere.

Test Plan:
- EXTRACT_MODE=0, REGIONS=4. Send one word with SOF=0101, META regions {A,B,C,D}, both DST_RDY=1 -> MFB word out after 1 cycle unchanged; one MVB word with VLD=0101 and DATA regions {A,–,C,–}; FIFO_STATUS returns to 0.
- EXTRACT_MODE=1. Send a 3-word packet: SOF on word 0, EOF region 2 on word 2 -> exactly one MVB word, VLD=0100, carrying the word-2 META of region 2; no MVB for words 0–1.
- FIFO_DEPTH=4, TX_MVB_DST_RDY=0. Send 6 SOF words -> 4 are accepted; RX_DST_RDY=0 after the 4th; FIFO_STATUS=4. Release MVB for 1 cycle -> the 5th word is accepted the following cycle.
- Hold TX_MFB_DST_RDY=0 with an empty FIFO -> RX_DST_RDY=0 and TX_MFB outputs stable; release -> streaming at 1 word/cycle with no loss or duplication.
- Simultaneous push/pop at FIFO_STATUS=2 for 10 cycles -> status stays 2 and MVB order is preserved.
- Assert RESET_N low mid-stream with the FIFO at 3 -> TX_MFB_SRC_RDY, TX_MVB_SRC_RDY and FIFO_STATUS are 0 immediately, with no clock needed; the stream restarts cleanly after release.
